// File: rtl/bcd_conversion_if.sv
// Handshake and result bundle between the multiplier, the BCD converter and the display stage.
interface bcd_conversion_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic                  valid;
  logic [W-1:0]          Mult;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output valid, Mult, input busy, done, sign, bcd);
  modport slave  (input valid, Mult, output busy, done, sign, bcd);
endinterface

// File: rtl/bcd_conversion.sv
// Signed binary to packed BCD converter, double-dabble with one shift-add-3 iteration per clock.
module bcd_conversion #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  bcd_conversion_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t                state;
  logic [W-1:0]          bin_reg;
  logic                  sign_reg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   shifted;
  logic [CW-1:0]         count;
  logic [W-1:0]          mag;

  // 16'h8000 negates to itself, which read unsigned is exactly 32768.
  always_comb mag = bus.Mult[W-1] ? -bus.Mult : bus.Mult;

  always_comb begin
    adjusted = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted[4*DIGITS-2:0], bin_reg[W-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bin_reg  <= '0;
      sign_reg <= 1'b0;
      scratch  <= '0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sign <= 1'b0;
      bus.bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.valid) begin
            bin_reg  <= mag;
            sign_reg <= bus.Mult[W-1];
            scratch  <= '0;
            count    <= CW'(W);
            bus.busy <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= shifted;
          bin_reg <= {bin_reg[W-2:0], 1'b0};
          count   <= count - CW'(1);
          // Final iteration publishes straight into the output registers so done and data align.
          if (count == CW'(1)) begin
            bus.bcd  <= shifted;
            bus.sign <= sign_reg;
            bus.done <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conversion.sv
// Self-checking bench for bcd_conversion: directed corner values, random values, handshake, reset abort, back-to-back.
module tb_bcd_conversion;

  localparam int W      = 16;
  localparam int DIGITS = 5;
  localparam int PERIOD = W + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [4*DIGITS-1:0] held_bcd  = '0;
  logic                held_sign = 1'b0;

  bcd_conversion_if #(.W(W), .DIGITS(DIGITS)) bus ();

  bcd_conversion #(.W(W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude by plain division.
  function automatic void model(input logic [W-1:0] v, output logic [4*DIGITS-1:0] b,
                                output logic s);
    int m;
    s = v[W-1];
    m = s ? (1 << W) - int'(v) : int'(v);
    b = '0;
    for (int d = 0; d < DIGITS; d++) begin
      b[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [W-1:0] value, input string tag, input bit disturb);
    logic [4*DIGITS-1:0] eb;
    logic                es;
    int                  n;
    int                  extra;
    model(value, eb, es);
    bus.valid = 1'b1;
    bus.Mult  = value;
    step();
    bus.valid = 1'b0;
    bus.Mult  = W'($urandom);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < W + 4) begin
      if (bus.bcd !== held_bcd || bus.sign !== held_sign)
        check({tag, " hold"}, {11'd0, bus.sign, bus.bcd}, {11'd0, held_sign, held_bcd});
      bus.valid = disturb && (n == 2 || n == 9);
      bus.Mult  = W'($urandom);
      step();
      n++;
    end
    bus.valid = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " sign"}, 32'(bus.sign), 32'(es));
    check({tag, " bcd"}, 32'(bus.bcd), 32'(eb));
    held_bcd  = eb;
    held_sign = es;
    step();
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({tag, " busy end"}, 32'(bus.busy), 32'd0);
    if (disturb) begin
      extra = 0;
      for (int k = 0; k < W + 4; k++) begin
        if (bus.done) extra++;
        step();
      end
      check({tag, " extra done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0]        mults[$];
    logic [4*DIGITS-1:0] eb;
    logic                es;
    int                  pulses;

    rst       = 1'b0;
    bus.valid = 1'b0;
    bus.Mult  = '0;
    repeat (3) step();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sign", 32'(bus.sign), 32'd0);
    check("reset bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b1;

    run_one(16'h4000, "pos16384", 1'b0);
    run_one(16'h0000, "zero", 1'b0);
    run_one(16'hFFEB, "neg21", 1'b0);
    run_one(16'h8000, "min", 1'b0);
    run_one(16'h7FFF, "max", 1'b0);
    run_one(16'hFFFF, "minus1", 1'b0);
    run_one(16'h0009, "nine", 1'b0);
    run_one(16'h2710, "tenk", 1'b0);
    for (int i = 0; i < 20; i++) run_one(W'($urandom), "random", 1'b0);

    run_one(16'h1234, "handshake", 1'b1);

    // Abort a conversion with reset; outputs clear immediately and no done follows.
    bus.valid = 1'b1;
    bus.Mult  = 16'hABCD;
    step();
    bus.valid = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort sign", 32'(bus.sign), 32'd0);
    check("abort bcd", 32'(bus.bcd), 32'd0);
    held_bcd  = '0;
    held_sign = 1'b0;
    step();
    rst    = 1'b1;
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (bus.done) pulses++;
      step();
    end
    check("abort no done", 32'(pulses), 32'd0);

    // valid held high: accepts at cycle 0, PERIOD, 2*PERIOD, ...
    for (int c = 0; c < 3 * PERIOD + 3; c++) begin
      bus.valid = 1'b1;
      bus.Mult  = W'($urandom);
      mults.push_back(bus.Mult);
      step();
      check("b2b done", 32'(bus.done), 32'((c % PERIOD) == W));
      if ((c % PERIOD) == W) begin
        model(mults[c - W], eb, es);
        check("b2b sign", 32'(bus.sign), 32'(es));
        check("b2b bcd", 32'(bus.bcd), 32'(eb));
        held_bcd  = eb;
        held_sign = es;
      end else begin
        check("b2b hold", {11'd0, bus.sign, bus.bcd}, {11'd0, held_sign, held_bcd});
      end
    end
    bus.valid = 1'b0;
    repeat (W + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
